// File: rtl/usb_fs_tx.sv
// Full-speed USB packet transmitter: byte stream in, SYNC + NRZI bit-stuffed
// data + EOP out on a tristate-able D+/D- pair.
module usb_fs_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_dp,
  output logic       usb_dm,
  output logic       usb_oe,
  output logic       busy,
  output logic       tx_underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  localparam logic [5:0] CNT_MAX = 6'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       shift_last_q, shift_last_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       hold_last_q, hold_last_d;
  logic       last_acc_q, last_acc_d;
  logic [2:0] ones_q, ones_d;
  logic       lvl_q, lvl_d;
  logic       dp_q, dp_d;
  logic       dm_q, dm_d;
  logic       eop_cnt_q, eop_cnt_d;

  logic       bit_stb;
  logic       accept;
  logic       advance;
  logic       emit;
  logic       tx_bit;
  logic [2:0] next_idx;

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    hold_last_d  = hold_last_q;
    last_acc_d   = last_acc_q;
    ones_d       = ones_q;
    lvl_d        = lvl_q;
    dp_d         = dp_q;
    dm_d         = dm_q;
    eop_cnt_d    = eop_cnt_q;
    advance      = 1'b0;
    emit         = 1'b0;
    tx_bit       = 1'b0;
    tx_underrun  = 1'b0;
    next_idx     = bit_idx_q + 3'd1;

    bit_stb  = (state_q != S_IDLE) && (cnt_q == CNT_MAX);
    // No new bytes once the packet end is known or while the EOP is on the line.
    tx_ready = !rst && !hold_full_q && !last_acc_q &&
               (state_q != S_EOP_SE0) && (state_q != S_EOP_J);
    accept   = tx_valid && tx_ready;
    cnt_d    = (state_q == S_IDLE || bit_stb) ? 6'd0 : cnt_q + 6'd1;

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      hold_last_d = tx_last;
      if (tx_last) last_acc_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_SYNC;
          bit_idx_d = 3'd0;
          emit      = 1'b1;
        end
      end
      S_SYNC: begin
        if (bit_stb) begin
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = next_idx;
            emit      = 1'b1;
            tx_bit    = (bit_idx_q == 3'd6);
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bit_stb) begin
          if (ones_q == 3'd6) begin
            state_d = S_STUFF;
            emit    = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_STUFF: begin
        if (bit_stb) advance = 1'b1;
      end
      S_EOP_SE0: begin
        if (bit_stb) begin
          if (eop_cnt_q) begin
            state_d = S_EOP_J;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end else begin
            eop_cnt_d = 1'b1;
          end
        end
      end
      S_EOP_J: begin
        if (bit_stb) begin
          state_d    = S_IDLE;
          last_acc_d = 1'b0;
          lvl_d      = 1'b1;
          ones_d     = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // End of a bit slot: next data bit, next byte from hold, or packet end.
    if (advance) begin
      if (bit_idx_q != 3'd7) begin
        state_d   = S_DATA;
        bit_idx_d = next_idx;
        emit      = 1'b1;
        tx_bit    = shift_q[next_idx];
      end else if (hold_full_q) begin
        state_d      = S_DATA;
        shift_d      = hold_q;
        shift_last_d = hold_last_q;
        hold_full_d  = 1'b0;
        bit_idx_d    = 3'd0;
        emit         = 1'b1;
        tx_bit       = hold_q[0];
      end else begin
        state_d     = S_EOP_SE0;
        eop_cnt_d   = 1'b0;
        dp_d        = 1'b0;
        dm_d        = 1'b0;
        tx_underrun = !shift_last_q;
      end
    end

    if (emit) begin
      lvl_d  = tx_bit ? lvl_q : !lvl_q;
      dp_d   = lvl_d;
      dm_d   = !lvl_d;
      ones_d = tx_bit ? ones_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 6'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      shift_last_q <= 1'b0;
      hold_q       <= 8'd0;
      hold_full_q  <= 1'b0;
      hold_last_q  <= 1'b0;
      last_acc_q   <= 1'b0;
      ones_q       <= 3'd0;
      lvl_q        <= 1'b1;
      dp_q         <= 1'b1;
      dm_q         <= 1'b0;
      eop_cnt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      hold_last_q  <= hold_last_d;
      last_acc_q   <= last_acc_d;
      ones_q       <= ones_d;
      lvl_q        <= lvl_d;
      dp_q         <= dp_d;
      dm_q         <= dm_d;
      eop_cnt_q    <= eop_cnt_d;
    end
  end

  assign usb_dp = dp_q;
  assign usb_dm = dm_q;
  assign usb_oe = (state_q != S_IDLE);
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_fs_tx.sv
// Self-checking bench for usb_fs_tx: line symbols captured per clk and
// compared with a bit-stream model of SYNC, stuffing, NRZI and EOP.
module tb_usb_fs_tx;

  localparam int CLK_DIV = 4;
  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } byte_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic       usb_dp, usb_dm, usb_oe, busy, tx_underrun;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;

  logic [1:0] cap[$];
  logic [1:0] exp_q[$];
  byte_t      tx_q[$];
  int         acc_q[$];
  int         fall_q[$];
  int         und_cnt = 0;
  int         und_idx = -1;
  int         busy_err = 0;
  int         eop_rdy_err = 0;
  logic       prev_oe = 1'b0;

  usb_fs_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .usb_dp(usb_dp),
    .usb_dm(usb_dm),
    .usb_oe(usb_oe),
    .busy(busy),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the pads mid-cycle, one sample per clk while driven.
  always @(negedge clk) begin
    if (usb_oe) begin
      cap.push_back({usb_dp, usb_dm});
      if (!usb_dp && !usb_dm && tx_ready) eop_rdy_err++;
    end
    if (busy !== usb_oe) busy_err++;
    if (tx_underrun) begin
      und_cnt++;
      und_idx = cap.size() - 1;
    end
    if (prev_oe && !usb_oe && !rst) fall_q.push_back(cyc);
    prev_oe = usb_oe;
  end

  task automatic clear_all();
    cap.delete();
    exp_q.delete();
    tx_q.delete();
    acc_q.delete();
    fall_q.delete();
    und_cnt = 0;
    und_idx = -1;
    busy_err = 0;
    eop_rdy_err = 0;
  endtask

  // Expected symbols for tx_q[first .. first+count-1] sent as one packet.
  task automatic build_expected(input int first, input int count);
    bit   bits[$];
    logic lvl;
    int   ones;
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int b = first; b < first + count; b++)
      for (int i = 0; i < 8; i++) bits.push_back(tx_q[b].data[i]);
    lvl = 1'b1;
    ones = 0;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = ~lvl;
      exp_q.push_back(lvl ? SYM_J : SYM_K);
      if (bits[i]) begin
        ones++;
        if (ones == 6) begin
          lvl = ~lvl;
          exp_q.push_back(lvl ? SYM_J : SYM_K);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
    exp_q.push_back(SYM_SE0);
    exp_q.push_back(SYM_SE0);
    exp_q.push_back(SYM_J);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < cap.size(); i++) begin
      if (i / CLK_DIV >= exp_q.size()) return i;
      if (cap[i] !== exp_q[i / CLK_DIV]) return i;
    end
    return -1;
  endfunction

  task automatic drive_q(input int gap_max);
    int waited;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i > 0 && gap_max > 0) begin
        int gap = $urandom_range(0, gap_max);
        tx_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      tx_valid = 1'b1;
      tx_data  = tx_q[i].data;
      tx_last  = tx_q[i].last;
      waited = 0;
      while (!tx_ready && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      if (!tx_ready) begin
        chk_cnt++;
        $display("[TB] FAIL accept_timeout byte %0d: tx_ready=0, required 1 within 2000 clks", i);
        tx_valid = 1'b0;
        return;
      end
      acc_q.push_back(cyc + 1);
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_falls(input int target);
    int waited = 0;
    while (fall_q.size() < target && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (fall_q.size() < target) begin
      chk_cnt++;
      $display("[TB] FAIL packet_end_timeout: falls=%0d, required %0d", fall_q.size(), target);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk_cnt++; if (usb_oe !== 1'b0) $display("[TB] FAIL rst_oe: got %b want 0", usb_oe); else pass_cnt++;
    chk_cnt++; if ({usb_dp, usb_dm} !== SYM_J) $display("[TB] FAIL rst_line: got %b want %b", {usb_dp, usb_dm}, SYM_J); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (tx_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %b want 0", tx_ready); else pass_cnt++;
    chk_cnt++; if (tx_underrun !== 1'b0) $display("[TB] FAIL rst_underrun: got %b want 0", tx_underrun); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (tx_ready !== 1'b1) $display("[TB] FAIL idle_ready: got %b want 1", tx_ready); else pass_cnt++;
  endtask

  task automatic run_fixed(input string name, input logic [7:0] b0, input logic [7:0] b1,
                           input int nbytes, input logic last_flag, input int want_len);
    int d;
    clear_all();
    tx_q.push_back('{b0, (nbytes == 1) ? last_flag : 1'b0});
    if (nbytes == 2) tx_q.push_back('{b1, last_flag});
    build_expected(0, nbytes);
    drive_q(0);
    wait_falls(1);
    chk_cnt++;
    if (cap.size() !== want_len) $display("[TB] FAIL %s_oe_len: got %0d clks want %0d", name, cap.size(), want_len);
    else pass_cnt++;
    d = first_diff();
    chk_cnt++;
    if (d != -1) $display("[TB] FAIL %s_line: clk %0d got %b want %b", name, d, cap[d],
                          (d / CLK_DIV < exp_q.size()) ? exp_q[d / CLK_DIV] : 2'bxx);
    else pass_cnt++;
    chk_cnt++;
    if (busy_err != 0) $display("[TB] FAIL %s_busy_vs_oe: %0d differing clks, want 0", name, busy_err);
    else pass_cnt++;
    chk_cnt++;
    if (eop_rdy_err != 0) $display("[TB] FAIL %s_ready_in_eop: %0d clks, want 0", name, eop_rdy_err);
    else pass_cnt++;
  endtask

  task automatic test_single_byte();
    run_fixed("single_d2", 8'hD2, 8'h00, 1, 1'b1, 76);
    chk_cnt++; if (und_cnt != 0) $display("[TB] FAIL single_underrun: got %0d want 0", und_cnt); else pass_cnt++;
  endtask

  task automatic test_stuff_mid();
    run_fixed("stuff_ff", 8'hC3, 8'hFF, 2, 1'b1, 112);
  endtask

  task automatic test_stuff_end();
    run_fixed("stuff_fc", 8'hC3, 8'hFC, 2, 1'b1, 112);
  endtask

  task automatic test_underrun();
    run_fixed("underrun", 8'hC3, 8'h00, 1, 1'b0, 19 * CLK_DIV);
    chk_cnt++; if (und_cnt != 1) $display("[TB] FAIL underrun_count: got %0d want 1", und_cnt); else pass_cnt++;
    chk_cnt++;
    if (und_idx != 16 * CLK_DIV - 1) $display("[TB] FAIL underrun_time: clk %0d want %0d", und_idx, 16 * CLK_DIV - 1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int d;
    clear_all();
    for (int i = 0; i < 4; i++) tx_q.push_back('{8'($urandom_range(0, 255)), (i % 2) == 1});
    build_expected(0, 2);
    build_expected(2, 2);
    drive_q(0);
    wait_falls(2);
    chk_cnt++;
    if (acc_q.size() != 4 || fall_q.size() < 1) $display("[TB] FAIL b2b_accepts: got %0d accepts want 4", acc_q.size());
    else if (acc_q[2] != fall_q[0] + 1) $display("[TB] FAIL b2b_restart: accept at %0d want %0d", acc_q[2], fall_q[0] + 1);
    else pass_cnt++;
    chk_cnt++;
    if (cap.size() !== exp_q.size() * CLK_DIV) $display("[TB] FAIL b2b_oe_len: got %0d want %0d", cap.size(), exp_q.size() * CLK_DIV);
    else pass_cnt++;
    d = first_diff();
    chk_cnt++;
    if (d != -1) $display("[TB] FAIL b2b_line: clk %0d got %b", d, cap[d]);
    else pass_cnt++;
    chk_cnt++;
    if (eop_rdy_err != 0) $display("[TB] FAIL b2b_ready_in_eop: %0d clks, want 0", eop_rdy_err);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int d, n;
    for (int p = 0; p < 6; p++) begin
      clear_all();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        tx_q.push_back('{($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)), i == n - 1});
      build_expected(0, n);
      drive_q(3);
      wait_falls(1);
      chk_cnt++;
      if (cap.size() !== exp_q.size() * CLK_DIV) $display("[TB] FAIL rand%0d_oe_len: got %0d want %0d", p, cap.size(), exp_q.size() * CLK_DIV);
      else pass_cnt++;
      d = first_diff();
      chk_cnt++;
      if (d != -1) $display("[TB] FAIL rand%0d_line: clk %0d got %b", p, d, cap[d]);
      else pass_cnt++;
      chk_cnt++;
      if (und_cnt != 0) $display("[TB] FAIL rand%0d_underrun: got %0d want 0", p, und_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    int d;
    clear_all();
    tx_q.push_back('{8'hC3, 1'b0});
    tx_q.push_back('{8'hFF, 1'b1});
    drive_q(0);
    while (cap.size() < 18 * CLK_DIV + 2 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (usb_oe !== 1'b0) $display("[TB] FAIL midrst_oe: got %b want 0", usb_oe); else pass_cnt++;
    chk_cnt++; if ({usb_dp, usb_dm} !== SYM_J) $display("[TB] FAIL midrst_line: got %b want %b", {usb_dp, usb_dm}, SYM_J); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (tx_ready !== 1'b0) $display("[TB] FAIL midrst_ready: got %b want 0", tx_ready); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_all();
    tx_q.push_back('{8'h3F, 1'b1});
    build_expected(0, 1);
    drive_q(0);
    wait_falls(1);
    chk_cnt++;
    if (cap.size() !== exp_q.size() * CLK_DIV) $display("[TB] FAIL postrst_oe_len: got %0d want %0d", cap.size(), exp_q.size() * CLK_DIV);
    else pass_cnt++;
    d = first_diff();
    chk_cnt++;
    if (d != -1) $display("[TB] FAIL postrst_line: clk %0d got %b", d, cap[d]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stuff_mid();
    test_stuff_end();
    test_underrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
